// File: rtl/sram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_arbiter_pkg
// Shared definitions for the two-master SRAM arbiter:
//   - bus geometry (data width, access-size code width, SRAM virtual address
//     width) matching the sram_controller header values
//   - access-size codes
//   - arbiter FSM state encoding
//   - arb_pick(): grant selection between the two request slots
// ---------------------------------------------------------------------------
package sram_arbiter_pkg;

  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;
  localparam int SRAM_VA_WIDTH = 19;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'b00;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'b01;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'b10;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  // Returns the master index to grant (0 = m0, 1 = m1). The round-robin
  // pointer only matters when both slots hold a request.
  function automatic logic arb_pick(input logic full0, input logic full1,
                                    input logic rr);
    return (full0 && full1) ? rr : full1;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
// One SRAM request/response bus. Used three times around the arbiter: the
// ibus (m0) and dbus (m1) links, where the arbiter is the slave, and the
// controller link, where the arbiter is the master.
//   addr   AW    request address
//   w_rb   1     1 = write, 0 = read
//   acc    ACCW  access-size code
//   wdata  DW    write data
//   req    1     single-cycle request pulse
//   rdata  DW    read data, valid with resp
//   resp   1     single-cycle completion pulse
//   fault  1     single-cycle error pulse (replaces resp)
// ---------------------------------------------------------------------------
interface sram_arbiter_if
  import sram_arbiter_pkg::*;
#(
  parameter int AW   = SRAM_VA_WIDTH,
  parameter int DW   = BUS_WIDTH,
  parameter int ACCW = BUS_ACC_WIDTH
) ();

  logic [AW-1:0]   addr;
  logic            w_rb;
  logic [ACCW-1:0] acc;
  logic [DW-1:0]   wdata;
  logic            req;
  logic [DW-1:0]   rdata;
  logic            resp;
  logic            fault;

  modport master (
    output addr, w_rb, acc, wdata, req,
    input  rdata, resp, fault
  );

  modport slave (
    input  addr, w_rb, acc, wdata, req,
    output rdata, resp, fault
  );

endinterface

// File: rtl/sram_arbiter_slot.sv
// ---------------------------------------------------------------------------
// sram_arbiter_slot
// Single-entry request holder for one master. Captures {w_rb,addr,acc,wdata}
// on a request pulse and keeps it until the arbiter frees it at the end of
// the transaction. A request arriving while the slot is still occupied is
// dropped and answered with a one-cycle overflow fault.
//   clk, rstn      clock, synchronous active-low reset
//   req_i          request pulse from the master
//   w_rb_i/addr_i/acc_i/wdata_i   request fields
//   free_i         owning transaction ends this cycle
//   full_o         slot holds a request
//   w_rb_o/addr_o/acc_o/wdata_o   held request fields
//   ovf_fault_o    registered pulse for a dropped request
// ---------------------------------------------------------------------------
module sram_arbiter_slot #(
  parameter int AW   = 19,
  parameter int DW   = 32,
  parameter int ACCW = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_i,
  input  logic            w_rb_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [ACCW-1:0] acc_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            free_i,
  output logic            full_o,
  output logic            w_rb_o,
  output logic [AW-1:0]   addr_o,
  output logic [ACCW-1:0] acc_o,
  output logic [DW-1:0]   wdata_o,
  output logic            ovf_fault_o
);

  logic            full_q,  full_d;
  logic            w_rb_q,  w_rb_d;
  logic [AW-1:0]   addr_q,  addr_d;
  logic [ACCW-1:0] acc_q,   acc_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            ovf_q,   ovf_d;

  // A request landing in the same cycle the slot is freed is accepted, so a
  // master may issue its next access alongside the completion of the last.
  always_comb begin
    full_d  = full_q;
    w_rb_d  = w_rb_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    wdata_d = wdata_q;
    ovf_d   = 1'b0;
    if (req_i && (!full_q || free_i)) begin
      full_d  = 1'b1;
      w_rb_d  = w_rb_i;
      addr_d  = addr_i;
      acc_d   = acc_i;
      wdata_d = wdata_i;
    end else begin
      if (req_i) begin
        ovf_d = 1'b1;
      end
      if (free_i) begin
        full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      full_q  <= 1'b0;
      w_rb_q  <= 1'b0;
      addr_q  <= '0;
      acc_q   <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      w_rb_q  <= w_rb_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

  assign full_o      = full_q;
  assign w_rb_o      = w_rb_q;
  assign addr_o      = addr_q;
  assign acc_o       = acc_q;
  assign wdata_o     = wdata_q;
  assign ovf_fault_o = ovf_q;

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Two-master front end for sram_controller. ibus (m0) and dbus (m1) requests
// are captured into per-master slots, granted round-robin onto the single
// controller port, and the controller response (rdata/resp/fault) is routed
// back to the owning master. A watchdog turns a missing response into a
// fault so neither bus can hang.
//   clk      clock, same domain as sram_controller
//   rstn     synchronous active-low reset
//   m0_bus   ibus link (arbiter is slave)
//   m1_bus   dbus link (arbiter is slave)
//   s_bus    controller link (arbiter is master); s_bus.fault is sampled
//            combinationally in the s_req cycle
// ---------------------------------------------------------------------------
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int AW      = SRAM_VA_WIDTH,
  parameter int DW      = BUS_WIDTH,
  parameter int ACCW    = BUS_ACC_WIDTH,
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            rstn,
  sram_arbiter_if.slave  m0_bus,
  sram_arbiter_if.slave  m1_bus,
  sram_arbiter_if.master s_bus
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WDOG_LIMIT = WDW'(TIMEOUT);

  logic            full0, full1, ovf0, ovf1, free0, free1;
  logic            w_rb0, w_rb1;
  logic [AW-1:0]   addr0, addr1;
  logic [ACCW-1:0] acc0, acc1;
  logic [DW-1:0]   wdata0, wdata1;

  arb_state_e      state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_q, rr_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic            s_req_q, s_req_d;
  logic            s_w_rb_q, s_w_rb_d;
  logic [AW-1:0]   s_addr_q, s_addr_d;
  logic [ACCW-1:0] s_acc_q, s_acc_d;
  logic [DW-1:0]   s_wdata_q, s_wdata_d;
  logic [DW-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic            m0_resp_q, m0_resp_d, m1_resp_q, m1_resp_d;
  logic            m0_fault_q, m0_fault_d, m1_fault_q, m1_fault_d;
  logic            grant, txn_resp, txn_fault;

  sram_arbiter_slot #(.AW(AW), .DW(DW), .ACCW(ACCW)) u_slot0 (
    .clk         (clk),
    .rstn        (rstn),
    .req_i       (m0_bus.req),
    .w_rb_i      (m0_bus.w_rb),
    .addr_i      (m0_bus.addr),
    .acc_i       (m0_bus.acc),
    .wdata_i     (m0_bus.wdata),
    .free_i      (free0),
    .full_o      (full0),
    .w_rb_o      (w_rb0),
    .addr_o      (addr0),
    .acc_o       (acc0),
    .wdata_o     (wdata0),
    .ovf_fault_o (ovf0)
  );

  sram_arbiter_slot #(.AW(AW), .DW(DW), .ACCW(ACCW)) u_slot1 (
    .clk         (clk),
    .rstn        (rstn),
    .req_i       (m1_bus.req),
    .w_rb_i      (m1_bus.w_rb),
    .addr_i      (m1_bus.addr),
    .acc_i       (m1_bus.acc),
    .wdata_i     (m1_bus.wdata),
    .free_i      (free1),
    .full_o      (full1),
    .w_rb_o      (w_rb1),
    .addr_o      (addr1),
    .acc_o       (acc1),
    .wdata_o     (wdata1),
    .ovf_fault_o (ovf1)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    wdog_d     = wdog_q;
    s_req_d    = 1'b0;
    s_w_rb_d   = s_w_rb_q;
    s_addr_d   = s_addr_q;
    s_acc_d    = s_acc_q;
    s_wdata_d  = s_wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_resp_d  = 1'b0;
    m1_resp_d  = 1'b0;
    m0_fault_d = 1'b0;
    m1_fault_d = 1'b0;
    free0      = 1'b0;
    free1      = 1'b0;
    grant      = 1'b0;
    txn_resp   = 1'b0;
    txn_fault  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        wdog_d = '0;
        if (full0 || full1) begin
          grant = arb_pick(full0, full1, rr_q);
          // The pointer advances only on contested grants, so an uncontested
          // grant does not cost the other master its turn.
          if (full0 && full1) begin
            rr_d = ~rr_q;
          end
          owner_d   = grant;
          s_req_d   = 1'b1;
          s_w_rb_d  = grant ? w_rb1  : w_rb0;
          s_addr_d  = grant ? addr1  : addr0;
          s_acc_d   = grant ? acc1   : acc0;
          s_wdata_d = grant ? wdata1 : wdata0;
          state_d   = ARB_WAIT;
        end
      end

      ARB_WAIT: begin
        wdog_d = wdog_q + WDW'(1);
        // Controller fault is only meaningful alongside s_req; a response
        // that arrives exactly at the limit still wins over the watchdog.
        if (s_req_q && s_bus.fault) begin
          txn_fault = 1'b1;
        end else if (s_bus.resp) begin
          txn_resp = 1'b1;
        end else if (wdog_q == WDOG_LIMIT) begin
          txn_fault = 1'b1;
        end

        if (txn_resp || txn_fault) begin
          state_d = ARB_IDLE;
          wdog_d  = '0;
          if (owner_q) begin
            free1      = 1'b1;
            m1_resp_d  = txn_resp;
            m1_fault_d = txn_fault;
            if (txn_resp) begin
              m1_rdata_d = s_bus.rdata;
            end
          end else begin
            free0      = 1'b1;
            m0_resp_d  = txn_resp;
            m0_fault_d = txn_fault;
            if (txn_resp) begin
              m0_rdata_d = s_bus.rdata;
            end
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ARB_IDLE;
      owner_q    <= 1'b0;
      rr_q       <= 1'b0;
      wdog_q     <= '0;
      s_req_q    <= 1'b0;
      s_w_rb_q   <= 1'b0;
      s_addr_q   <= '0;
      s_acc_q    <= '0;
      s_wdata_q  <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_resp_q  <= 1'b0;
      m1_resp_q  <= 1'b0;
      m0_fault_q <= 1'b0;
      m1_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      wdog_q     <= wdog_d;
      s_req_q    <= s_req_d;
      s_w_rb_q   <= s_w_rb_d;
      s_addr_q   <= s_addr_d;
      s_acc_q    <= s_acc_d;
      s_wdata_q  <= s_wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_resp_q  <= m0_resp_d;
      m1_resp_q  <= m1_resp_d;
      m0_fault_q <= m0_fault_d;
      m1_fault_q <= m1_fault_d;
    end
  end

  assign s_bus.req   = s_req_q;
  assign s_bus.w_rb  = s_w_rb_q;
  assign s_bus.addr  = s_addr_q;
  assign s_bus.acc   = s_acc_q;
  assign s_bus.wdata = s_wdata_q;

  // An overflow fault can only hit a master whose slot is not being freed,
  // so it never coincides with that master's own resp or transaction fault.
  assign m0_bus.rdata = m0_rdata_q;
  assign m0_bus.resp  = m0_resp_q;
  assign m0_bus.fault = m0_fault_q | ovf0;
  assign m1_bus.rdata = m1_rdata_q;
  assign m1_bus.resp  = m1_resp_q;
  assign m1_bus.fault = m1_fault_q | ovf1;

endmodule
